// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the unified memory bus arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// rtl/mem_arbiter_arb_prio.sv - combinational winner select, data first unless fetch is starved
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              inst_req,
  input  logic              data_req,
  input  logic [WAIT_W-1:0] wait_cnt,
  input  logic              excl_en,
  input  owner_t            excl_owner,
  output logic              grant,
  output owner_t            winner
);

  logic inst_elig;
  logic data_elig;

  // The requester being answered still holds req during its ready cycle.
  always_comb begin
    inst_elig = inst_req & ~(excl_en & (excl_owner == OWN_INST));
    data_elig = data_req & ~(excl_en & (excl_owner == OWN_DATA));
    grant     = inst_elig | data_elig;
    if (data_elig && !(inst_elig && (wait_cnt == WAIT_W'(MAX_WAIT))))
      winner = OWN_DATA;
    else
      winner = OWN_INST;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter driving one variable-latency req/ack memory bus
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  output logic              inst_stall,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              data_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  owner_t            winner;
  logic [WAIT_W-1:0] wait_cnt;
  logic              grant;
  logic              take;

  arb_prio #(.MAX_WAIT(MAX_WAIT)) u_arb_prio (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .wait_cnt   (wait_cnt),
    .excl_en    (state == RESP),
    .excl_owner (owner),
    .grant      (grant),
    .winner     (winner)
  );

  assign take       = (state != BUSY) & grant;
  assign inst_ready = (state == RESP) & (owner == OWN_INST);
  assign data_ready = (state == RESP) & (owner == OWN_DATA);
  assign inst_stall = inst_req & ~inst_ready;
  assign data_stall = data_req & ~data_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (bus_ack) state_nxt = RESP;
      RESP:    state_nxt = grant ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_INST;
      wait_cnt   <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner     <= winner;
        bus_req   <= 1'b1;
        bus_we    <= (winner == OWN_DATA) & data_we;
        bus_addr  <= (winner == OWN_DATA) ? data_addr : inst_addr;
        bus_wdata <= (winner == OWN_DATA) ? data_wdata : '0;
      end else if ((state == BUSY) && bus_ack) begin
        bus_req <= 1'b0;
        if (owner == OWN_INST)
          inst_rdata <= bus_rdata;
        else if (!bus_we)
          data_rdata <= bus_rdata;
      end
      // A fetch that is being answered this cycle is not waiting.
      if (!inst_req)
        wait_cnt <= '0;
      else if (take && (winner == OWN_INST))
        wait_cnt <= '0;
      else if (take && !inst_ready && (wait_cnt != WAIT_W'(MAX_WAIT)))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a transfer-level model
module tb_mem_arbiter;

  localparam int MAXW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        inst_stall;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        data_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ready (inst_ready),
    .inst_stall (inst_stall),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_ready (data_ready),
    .data_stall (data_stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one transfer in flight at most; resp_who = -1 none, 0 inst, 1 data.
  bit        m_inflight;
  int        m_own;
  int        resp_who;
  int        m_wait;
  bit        e_req;
  bit        e_we;
  bit [31:0] e_addr;
  bit [31:0] e_wdata;
  bit [31:0] e_irdata;
  bit [31:0] e_drdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int  prev_resp;
    bit  ei, ed, took;
    int  win;
    if (!rst) begin
      m_inflight = 0; m_own = 0; resp_who = -1; m_wait = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
      return;
    end
    prev_resp = resp_who;
    resp_who  = -1;
    took      = 0;
    win       = 0;
    if (m_inflight) begin
      if (bus_ack) begin
        m_inflight = 0;
        e_req      = 0;
        resp_who   = m_own;
        if (m_own == 0) e_irdata = bus_rdata;
        else if (!e_we) e_drdata = bus_rdata;
      end
    end else begin
      ei = inst_req && (prev_resp != 0);
      ed = data_req && (prev_resp != 1);
      if (ei || ed) begin
        win        = (ed && !(ei && m_wait == MAXW)) ? 1 : 0;
        took       = 1;
        m_inflight = 1;
        m_own      = win;
        e_req      = 1;
        e_we       = (win == 1) ? data_we : 1'b0;
        e_addr     = (win == 1) ? data_addr : inst_addr;
        e_wdata    = (win == 1) ? data_wdata : 32'h0;
      end
    end
    if (!inst_req) m_wait = 0;
    else if (took && win == 0) m_wait = 0;
    else if (took && win == 1 && prev_resp != 0 && m_wait < MAXW) m_wait = m_wait + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    chk("bus_req",    bus_req,    e_req);
    chk("bus_we",     bus_we,     e_we);
    chk("bus_addr",   bus_addr,   e_addr);
    chk("bus_wdata",  bus_wdata,  e_wdata);
    chk("inst_ready", inst_ready, resp_who == 0);
    chk("data_ready", data_ready, resp_who == 1);
    chk("inst_rdata", inst_rdata, e_irdata);
    chk("data_rdata", data_rdata, e_drdata);
    chk("inst_stall", inst_stall, inst_req & (resp_who != 0));
    chk("data_stall", data_stall, data_req & (resp_who != 1));
    chk("ready_excl", inst_ready & data_ready, 1'b0);
  endtask

  initial begin
    int lat;
    rst = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0;
    data_addr = 0; data_wdata = 0; bus_rdata = 0; bus_ack = 0;
    step();
    step();
    chk("reset_bus_req", bus_req, 1'b0);
    rst = 1;
    step();

    // single fetch, ack latency 1
    inst_req = 1; inst_addr = 32'h100;
    step();
    chk("fetch_bus_req", bus_req, 1'b1);
    bus_ack = 1; bus_rdata = 32'h2408000A;
    step();
    chk("fetch_ready", inst_ready, 1'b1);
    chk("fetch_rdata", inst_rdata, 32'h2408000A);
    inst_req = 0; bus_ack = 0;
    step();

    // single write, ack latency 3
    data_req = 1; data_we = 1; data_addr = 32'h40; data_wdata = 32'hDEADBEEF;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("wr_addr_stable", bus_addr, 32'h40);
      chk("wr_data_stable", bus_wdata, 32'hDEADBEEF);
      chk("wr_we_stable", bus_we, 1'b1);
      bus_ack = (k == 2); bus_rdata = 32'h55AA55AA;
      step();
    end
    chk("wr_ready", data_ready, 1'b1);
    chk("wr_rdata_kept", data_rdata, 32'h0);
    data_req = 0; data_we = 0; bus_ack = 0;
    step();

    // simultaneous requests: data first, fetch granted in the data RESP cycle
    inst_req = 1; inst_addr = 32'h200; data_req = 1; data_addr = 32'h80;
    step();
    chk("sim_first_data", bus_addr, 32'h80);
    bus_ack = 1; bus_rdata = 32'h11111111;
    step();
    chk("sim_data_ready", data_ready, 1'b1);
    data_req = 0; bus_ack = 0;
    step();
    chk("sim_inst_next", bus_addr, 32'h200);
    chk("sim_inst_stall", inst_stall, 1'b1);
    bus_ack = 1; bus_rdata = 32'h22222222;
    step();
    chk("sim_inst_ready", inst_ready, 1'b1);
    inst_req = 0; bus_ack = 0;
    step();

    // reset mid-transfer, late ack ignored
    inst_req = 1; inst_addr = 32'h300;
    step();
    rst = 0;
    step();
    chk("rst_drop_req", bus_req, 1'b0);
    rst = 1; inst_req = 0; bus_ack = 1;
    step();
    chk("rst_no_ready", inst_ready | data_ready, 1'b0);
    bus_ack = 0;
    step();

    // abandoned request still completes once
    inst_req = 1; inst_addr = 32'h304;
    step();
    inst_req = 0;
    step();
    bus_ack = 1; bus_rdata = 32'h33333333;
    step();
    chk("abandon_ready", inst_ready, 1'b1);
    bus_ack = 0;
    step();
    step();
    chk("abandon_idle", bus_req, 1'b0);

    // randomized traffic with random bus latency and rare resets
    lat = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (inst_req && resp_who == 0) inst_req = 0;
      else if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_addr = $urandom_range(0, 63) * 4;
      end
      if (data_req && resp_who == 1) data_req = 0;
      else if (!data_req && $urandom_range(0, 1) == 0) begin
        data_req = 1; data_we = $urandom_range(0, 1);
        data_addr = 32'h1000 + $urandom_range(0, 63) * 4; data_wdata = $urandom;
      end
      if (!bus_req || bus_ack) begin
        bus_ack = 0; lat = $urandom_range(0, 3);
      end else if (lat == 0) begin
        bus_ack = 1; bus_rdata = $urandom;
      end else lat--;
      rst = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
